// File: rtl/minirisc_pkg.sv
// ---------------------------------------------------------------------------
// minirisc_pkg
// Shared types for the minirisc program loader: loader FSM states, the
// default load-terminating opcode and the 16-bit instruction word layout.
// ---------------------------------------------------------------------------
package minirisc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] END_OP_DEFAULT = 8'h00;
    localparam int         INST_W         = 16;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
    } inst_t;

endpackage

// File: rtl/minirisc_prog_ram.sv
// ---------------------------------------------------------------------------
// minirisc_prog_ram
// DEPTH x 16-bit program buffer: one synchronous write port, one
// asynchronous (combinational) read port.
// Ports:
//   clk      in   write clock
//   i_we     in   write enable
//   i_waddr  in   write address (AW bits)
//   i_wdata  in   instruction word to store
//   i_raddr  in   read address (AW bits)
//   o_rdata  out  instruction word at i_raddr
// ---------------------------------------------------------------------------
module minirisc_prog_ram
    import minirisc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  inst_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output inst_t         o_rdata
);

    inst_t r_mem [DEPTH];

    // NOTE: the array has no reset. Every entry is written before it is
    // read, so clearing it would add nothing but reset fan-out.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/minirisc_prog_loader.sv
// ---------------------------------------------------------------------------
// minirisc_prog_loader
// Captures opcode/operand byte pairs from the pad bus, stores them as
// 16-bit instruction words in a small program buffer, then issues them in
// order to the core over a valid/ready interface. An END_OP opcode ends
// the load; filling the buffer ends it too and sets the sticky overflow.
//
// Build option: define MINIRISC_LOOP_EN to make the program repeat from
// pc 0 after its last word (until flush/rst) instead of stopping in DONE.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        synchronous clear back to IDLE (beats any same-cycle
//                load write or issue handshake)
//   in_valid / in_ready / in_opcode / in_operand   program byte input
//   inst_valid / inst_ready / inst_word / inst_pc  instruction output
//   prog_len     number of stored instructions (AW+1 bits)
//   overflow     sticky: buffer filled before END_OP
//   busy         loader not IDLE
// ---------------------------------------------------------------------------
module minirisc_prog_loader
    import minirisc_pkg::*;
#(
    parameter int         DEPTH  = 16,
    parameter int         AW     = $clog2(DEPTH),
    parameter logic [7:0] END_OP = END_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [7:0]        in_opcode,
    input  logic [7:0]        in_operand,
    output logic              in_ready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_word,
    output logic [AW-1:0]     inst_pc,
    output logic [AW:0]       prog_len,
    output logic              overflow,
    output logic              busy
);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_prog_len;
    logic          r_overflow;

    logic          w_in_ready;
    logic          w_inst_valid;
    logic          w_wr_en;
    logic          w_rptr_inc;
    logic          w_rptr_clr;
    logic          w_len_load;
    logic [AW:0]   w_len_val;
    logic          w_ovf_set;
    logic          w_last;
    inst_t         w_wdata;
    inst_t         w_rdata;

    assign w_wdata = '{opcode: in_opcode, operand: in_operand};
    assign w_last  = ({1'b0, r_rptr} == (r_prog_len - (AW+1)'(1)));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_inst_valid = 1'b0;
        w_wr_en      = 1'b0;
        w_rptr_inc   = 1'b0;
        w_rptr_clr   = 1'b0;
        w_len_load   = 1'b0;
        w_len_val    = '0;
        w_ovf_set    = 1'b0;

        case (r_state)
            // IDLE treats its first pair exactly like LOAD does, so the two
            // share one decode. Refusing pairs during flush keeps a pair
            // from being accepted and then silently dropped.
            IDLE, LOAD: begin
                w_in_ready = ~flush;
                if (in_valid && w_in_ready) begin
                    if (in_opcode == END_OP) begin
                        w_len_load   = 1'b1;
                        w_len_val    = {1'b0, r_wptr};
                        w_state_next = (r_wptr == '0) ? IDLE : RUN;
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_wptr == AW'(DEPTH - 1)) begin
                            // This write fills the buffer; wptr wraps to 0.
                            w_ovf_set    = 1'b1;
                            w_len_load   = 1'b1;
                            w_len_val    = (AW+1)'(DEPTH);
                            w_state_next = RUN;
                        end else begin
                            w_state_next = LOAD;
                        end
                    end
                end
            end

            RUN: begin
                w_inst_valid = 1'b1;
                if (inst_ready) begin
                    w_rptr_inc = 1'b1;
                    if (w_last) begin
`ifdef MINIRISC_LOOP_EN
                        w_rptr_clr = 1'b1;
`else
                        w_state_next = DONE;
`endif
                    end
                end
            end

            DONE: begin
                w_state_next = DONE;
            end
        endcase

        if (flush) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, program length, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_prog_len <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_prog_len <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rptr_clr) begin
                r_rptr <= '0;
            end else if (w_rptr_inc) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_len_load) begin
                r_prog_len <= w_len_val;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    minirisc_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // in_ready is masked by rst so every output reads 0 while reset is held.
    assign in_ready   = w_in_ready & ~rst;
    assign inst_valid = w_inst_valid;
    assign inst_word  = w_inst_valid ? w_rdata : '0;
    assign inst_pc    = w_inst_valid ? r_rptr : '0;
    assign prog_len   = r_prog_len;
    assign overflow   = r_overflow;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_minirisc_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_minirisc_prog_loader
// Self-checking bench for minirisc_prog_loader. A transaction-level model
// (queue of expected stored words, overflow flag) predicts acceptance of
// each byte pair and the issued instruction stream; directed programs are
// followed by randomized programs with random core back-pressure.
// ---------------------------------------------------------------------------
module tb_minirisc_prog_loader;

    localparam int         DEPTH  = 16;
    localparam int         AW     = 4;
    localparam logic [7:0] END_OP = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [7:0]    in_opcode;
    logic [7:0]    in_operand;
    logic          in_ready;
    logic          inst_valid;
    logic          inst_ready;
    logic [15:0]   inst_word;
    logic [AW-1:0] inst_pc;
    logic [AW:0]   prog_len;
    logic          overflow;
    logic          busy;

    minirisc_prog_loader #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .END_OP (END_OP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_operand (in_operand),
        .in_ready   (in_ready),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_word  (inst_word),
        .inst_pc    (inst_pc),
        .prog_len   (prog_len),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] stim_q[$];
    logic [15:0] m_prog[$];
    bit          m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair for one cycle; report whether the loader took it.
    task automatic send_pair(input logic [7:0] op, input logic [7:0] opd, output bit acc);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_operand = opd;
        #1;
        acc = in_ready;
        step();
        in_valid = 1'b0;
    endtask

    // Offer every pair of stim_q; model which get accepted and what is stored.
    task automatic load();
        bit acc;
        bit stopped;
        m_prog.delete();
        m_ovf   = 1'b0;
        stopped = 1'b0;
        foreach (stim_q[i]) begin
            send_pair(stim_q[i][15:8], stim_q[i][7:0], acc);
            check("accept", 32'(acc), 32'(!stopped));
            if (!stopped) begin
                if (stim_q[i][15:8] == END_OP) begin
                    stopped = 1'b1;
                end else begin
                    m_prog.push_back(stim_q[i]);
                    if (m_prog.size() == DEPTH) begin
                        stopped = 1'b1;
                        m_ovf   = 1'b1;
                    end
                end
            end
        end
        in_valid = 1'b0;
        #1;
        check("prog_len", 32'(prog_len), 32'(m_prog.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy_after_load", 32'(busy), 32'(m_prog.size() > 0));
        check("in_ready_after_load", 32'(in_ready), 32'(m_prog.size() == 0));
        check("inst_valid_after_load", 32'(inst_valid), 32'(m_prog.size() > 0));
    endtask

    // Collect `target` handshakes. mode 0: ready=1, 1: toggling, 2: random.
    // With stop_pc >= 0, return just before the edge of the handshake at
    // that pc so the caller can hit it with rst or flush.
    task automatic drain(input int mode, input int target, input int stop_pc, output bit hit_stop);
        int          idx = 0;
        int          cyc = 0;
        int          n   = m_prog.size();
        bit          prev_stall = 1'b0;
        logic [15:0] prev_word  = '0;
        logic [AW-1:0] prev_pc  = '0;
        hit_stop = 1'b0;
        while (idx < target && cyc < 400) begin
            case (mode)
                0:       inst_ready = 1'b1;
                1:       inst_ready = (cyc % 2 == 0);
                default: inst_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (inst_valid) begin
                if (prev_stall) begin
                    check("hold_word", 32'(inst_word), 32'(prev_word));
                    check("hold_pc", 32'(inst_pc), 32'(prev_pc));
                end
                if (inst_ready) begin
                    check("issue_word", 32'(inst_word), 32'(m_prog[idx % n]));
                    check("issue_pc", 32'(inst_pc), 32'(idx % n));
                    if (stop_pc >= 0 && (idx % n) == stop_pc) begin
                        hit_stop = 1'b1;
                        return;
                    end
                    idx++;
                end
                prev_stall = !inst_ready;
                prev_word  = inst_word;
                prev_pc    = inst_pc;
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        inst_ready = 1'b0;
        check("drain_count", 32'(idx), 32'(target));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_prog_len", 32'(prog_len), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_inst_valid", 32'(inst_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Issue the modelled program and check the end-of-program behaviour.
    task automatic run_program(input int mode);
        bit s;
`ifdef MINIRISC_LOOP_EN
        drain(mode, 2 * m_prog.size() + 1, -1, s);
        #1;
        check("loop_still_valid", 32'(inst_valid), 32'd1);
`else
        drain(mode, m_prog.size(), -1, s);
        #1;
        check("done_inst_valid", 32'(inst_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        step();
        check("done_stays_idle_out", 32'(inst_valid), 32'd0);
        check("done_prog_len", 32'(prog_len), 32'(m_prog.size()));
        check("done_overflow", 32'(overflow), 32'(m_ovf));
`endif
        do_flush();
    endtask

    task automatic make_count_prog(input int first, input int n, input bit with_end);
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            stim_q.push_back({8'(first + i), 8'(first + i)});
        end
        if (with_end) stim_q.push_back({END_OP, 8'h00});
    endtask

    initial begin
        bit s;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_operand = '0;
        inst_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_word", 32'(inst_word), 32'd0);
        check("rst_inst_pc", 32'(inst_pc), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Nine words then END_OP, core always ready.
        make_count_prog(1, 9, 1'b1);
        load();
        run_program(0);

        // Same program, core ready toggling.
        make_count_prog(1, 9, 1'b1);
        load();
        run_program(1);

        // 17 pairs without END_OP: 16 stored, 17th refused, overflow set.
        make_count_prog(8'h11, 17, 1'b0);
        load();
        run_program(0);

        // END_OP as first pair: nothing stored, straight back to IDLE.
        stim_q.delete();
        stim_q.push_back({END_OP, 8'h00});
        load();
        for (int i = 0; i < 4; i++) begin
            check("empty_inst_valid", 32'(inst_valid), 32'd0);
            step();
        end
        check("empty_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-run at pc 4.
        make_count_prog(1, 9, 1'b1);
        load();
        drain(0, 9, 4, s);
        check("rst_stop_hit", 32'(s), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_prog_len", 32'(prog_len), 32'd0);
        check("midrst_inst_word", 32'(inst_word), 32'd0);
        inst_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // Flush colliding with a handshake at pc 4, then a 2-word reload.
        make_count_prog(1, 9, 1'b1);
        load();
        drain(0, 9, 4, s);
        check("flush_stop_hit", 32'(s), 32'd1);
        flush = 1'b1;
        step();
        flush      = 1'b0;
        inst_ready = 1'b0;
        check("midflush_busy", 32'(busy), 32'd0);
        check("midflush_prog_len", 32'(prog_len), 32'd0);
        check("midflush_inst_valid", 32'(inst_valid), 32'd0);
        stim_q.delete();
        stim_q.push_back(16'h3344);
        stim_q.push_back(16'h5566);
        stim_q.push_back({END_OP, 8'h00});
        load();
        run_program(2);

        // Two-word program (repeats when MINIRISC_LOOP_EN is defined).
        stim_q.delete();
        stim_q.push_back(16'hAA01);
        stim_q.push_back(16'hAA02);
        stim_q.push_back({END_OP, 8'h00});
        load();
        run_program(0);

        // Random programs, lengths spanning empty to past overflow.
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(0, DEPTH + 2);
            stim_q.delete();
            for (int k = 0; k < n; k++) begin
                stim_q.push_back({8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))});
            end
            stim_q.push_back({END_OP, 8'($urandom_range(0, 255))});
            load();
            if (m_prog.size() > 0) begin
                run_program(2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
